fsm2_stim_checker: RTL and testbench

- Self-checking driver/monitor for the two-flop falling-edge controller, which has inputs a, b, clk and outputs y, z.
- Generates the a/b input stream on rising edges and samples y/z on the following rising edge.
- Compares the samples against an internal cycle-accurate model and reports pass/fail, error count and the first failing vector.
- Sits beside the controller in the lab top-level; usable on board and in simulation.

---
 rtl/fsm2_stim_checker.sv | 156 +++++++++++++++
 tb/tb_fsm2_stim_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fsm2_stim_checker.sv
// fsm2_stim_checker: stimulus driver and cycle-accurate checker for the two-flop falling-edge controller.
// Ports:
//   clk              system clock, shared with the controller under test
//   rst_n            asynchronous active-low reset
//   start_i          one-cycle pulse, begins a run when idle
//   mode_i           0 = index sweep, 1 = LFSR vectors (sampled at start)
//   dut_y_i/dut_z_i  controller outputs
//   dut_a_o/dut_b_o  controller inputs
//   busy_o           run in progress
//   done_o           one-cycle pulse at end of run
//   pass_o           last run had zero mismatches, held until next start
//   err_cnt_o        saturating mismatch count
//   first_err_idx_o  index of first mismatching vector, all-ones if none
module fsm2_stim_checker #(
    parameter int         NUM_VEC   = 64,
    parameter int         CNT_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             dut_y_i,
    input  logic             dut_z_i,
    output logic             dut_a_o,
    output logic             dut_b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_idx_o
);
    // The vector index must count to NUM_VEC-1 and expose bits [1:0] even when CNT_W is narrower.
    localparam int LOG_N = $clog2(NUM_VEC);
    localparam int IW0   = LOG_N > CNT_W ? LOG_N : CNT_W;
    localparam int IDX_W = IW0 < 2 ? 2 : IW0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, RUN, LAST, FIN} state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               q1_q, q1_d, q2_q, q2_d;
    logic               a_q, a_d, b_q, b_d;
    logic               done_q, done_d, pass_q, pass_d;
    logic [CNT_W-1:0]   err_q, err_d, first_q, first_d;
    logic               nq1, nq2, exp_y, exp_z, mism;

    // Model of the controller for the vector currently on dut_a/dut_b.
    assign nq1   = a_q | (b_q & ~q2_q);
    assign nq2   = ~nq1 & q1_q;
    assign exp_y = nq1;
    assign exp_z = ~nq1 | (b_q & ~nq2);
    assign mism  = (dut_y_i != exp_y) | (dut_z_i != exp_z);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SYNC0;
                mode_d  = mode_i;
                idx_d   = '0;
                lfsr_d  = LFSR_SEED;
                err_d   = '0;
                first_d = '1;
                pass_d  = 1'b0;
                a_d     = 1'b1;
                b_d     = 1'b0;
            end
            SYNC0: state_d = SYNC1;
            SYNC1: begin
                // Two cycles of a=1,b=0 leave the controller at Q1=1, Q2=0.
                q1_d    = 1'b1;
                q2_d    = 1'b0;
                a_d     = mode_q ? lfsr_q[1] : idx_q[1];
                b_d     = mode_q ? lfsr_q[0] : idx_q[0];
                state_d = (NUM_VEC == 1) ? LAST : RUN;
            end
            RUN: begin
                idx_d   = idx_q + 1'b1;
                lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                q1_d    = nq1;
                q2_d    = nq2;
                a_d     = mode_q ? lfsr_d[1] : idx_d[1];
                b_d     = mode_q ? lfsr_d[0] : idx_d[0];
                state_d = (idx_d == LAST_IDX) ? LAST : RUN;
            end
            LAST: begin
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == RUN || state_q == LAST) && mism) begin
            if (err_q == '0) first_d = idx_q[CNT_W-1:0];
            if (err_q != '1) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            q1_q    <= 1'b0;
            q2_q    <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign dut_a_o         = a_q;
    assign dut_b_o         = b_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_idx_o = first_q;
endmodule

// File: tb/tb_fsm2_stim_checker.sv
// tb_fsm2_stim_checker: directed bench for fsm2_stim_checker with behavioural controllers and fault injection.
module tb_fsm2_stim_checker;
    logic       clk = 1'b0, rst_n = 1'b0, mode = 1'b0, scramble = 1'b0;
    logic [3:0] st = '0, da, db, cy, cz, bs, dn, ps;
    logic [3:0] q1 = '0, q2 = '0;
    logic [1:0] fy [4];
    logic [1:0] fz [4];
    logic [7:0] e0, f0, e1, f1, e3, f3;
    logic [1:0] e2, f2;
    logic [3:0] va, vb;
    int         n_chk = 0, n_pass = 0, first_done, n_done;

    always #50 clk = ~clk;

    fsm2_stim_checker #(.NUM_VEC(4)) u0 (.clk(clk), .rst_n(rst_n), .start_i(st[0]), .mode_i(mode),
        .dut_y_i(cy[0]), .dut_z_i(cz[0]), .dut_a_o(da[0]), .dut_b_o(db[0]), .busy_o(bs[0]),
        .done_o(dn[0]), .pass_o(ps[0]), .err_cnt_o(e0), .first_err_idx_o(f0));
    fsm2_stim_checker #(.NUM_VEC(64)) u1 (.clk(clk), .rst_n(rst_n), .start_i(st[1]), .mode_i(mode),
        .dut_y_i(cy[1]), .dut_z_i(cz[1]), .dut_a_o(da[1]), .dut_b_o(db[1]), .busy_o(bs[1]),
        .done_o(dn[1]), .pass_o(ps[1]), .err_cnt_o(e1), .first_err_idx_o(f1));
    fsm2_stim_checker #(.NUM_VEC(16), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .start_i(st[2]), .mode_i(mode),
        .dut_y_i(cy[2]), .dut_z_i(cz[2]), .dut_a_o(da[2]), .dut_b_o(db[2]), .busy_o(bs[2]),
        .done_o(dn[2]), .pass_o(ps[2]), .err_cnt_o(e2), .first_err_idx_o(f2));
    fsm2_stim_checker #(.NUM_VEC(1)) u3 (.clk(clk), .rst_n(rst_n), .start_i(st[3]), .mode_i(mode),
        .dut_y_i(cy[3]), .dut_z_i(cz[3]), .dut_a_o(da[3]), .dut_b_o(db[3]), .busy_o(bs[3]),
        .done_o(dn[3]), .pass_o(ps[3]), .err_cnt_o(e3), .first_err_idx_o(f3));

    // Behavioural controllers: flops on the falling edge, scramble loads random state.
    always @(negedge clk) begin
        if (scramble) begin
            q1 <= 4'($urandom);
            q2 <= 4'($urandom);
        end else begin
            for (int i = 0; i < 4; i++) begin
                q1[i] <= da[i] | (db[i] & ~q2[i]);
                q2[i] <= ~(da[i] | (db[i] & ~q2[i])) & q1[i];
            end
        end
    end

    // Fault codes: 0 none, 1 stuck-at-0, 2 stuck-at-1.
    always_comb begin
        cy = '0;
        cz = '0;
        for (int i = 0; i < 4; i++) begin
            cy[i] = fy[i] == 2'd1 ? 1'b0 : fy[i] == 2'd2 ? 1'b1 : q1[i];
            cz[i] = fz[i] == 2'd1 ? 1'b0 : fz[i] == 2'd2 ? 1'b1 : (~q1[i] | (db[i] & ~q2[i]));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #10;
    endtask

    // Starts instance k, optionally keeps start asserted through cycle hold, logs done pulses and vectors 0..3.
    task automatic run(input int k, input bit m, input int hold, input int budget);
        mode  = m;
        st[k] = 1'b1;
        tick();
        st[k] = hold > 0;
        first_done = -1;
        n_done = 0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (c >= 2 && c <= 5) begin
                va[c-2] = da[k];
                vb[c-2] = db[k];
            end
            if (dn[k]) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (c >= hold) st[k] = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] lfsr_vec [4];
        lfsr_vec = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            fy[i] = 2'd0;
            fz[i] = 2'd0;
        end
        scramble = 1'b1;
        tick();
        tick();
        check("rst_busy", bs[0], 1'b0);
        check("rst_done", dn[0], 1'b0);
        check("rst_pass", ps[0], 1'b0);
        check("rst_a", da[0], 1'b0);
        check("rst_b", db[0], 1'b0);
        check("rst_err", e0, 8'h00);
        check("rst_first", f0, 8'hFF);
        check("rst_first_w2", f2, 2'b11);
        rst_n = 1'b1;
        scramble = 1'b0;
        tick();
        tick();
        tick();
        check("idle_after_rst", bs[0], 1'b0);

        run(0, 1'b0, 6, 14);
        check("sweep_done_at", first_done, 7);
        check("sweep_one_done", n_done, 1);
        for (int k = 0; k < 4; k++) check($sformatf("sweep_vec%0d", k), {va[k], vb[k]}, k);
        check("sweep_pass", ps[0], 1'b1);
        check("sweep_err", e0, 8'h00);
        check("sweep_first", f0, 8'hFF);
        check("sweep_idle", bs[0], 1'b0);

        fz[0] = 2'd1;
        run(0, 1'b0, 0, 12);
        check("zfault_done_at", first_done, 7);
        check("zfault_err", e0, 8'd3);
        check("zfault_first", f0, 8'd0);
        check("zfault_pass", ps[0], 1'b0);
        fz[0] = 2'd0;

        scramble = 1'b1;
        tick();
        tick();
        scramble = 1'b0;
        run(1, 1'b1, 0, 80);
        check("lfsr_done_at", first_done, 67);
        for (int k = 0; k < 4; k++) check($sformatf("lfsr_vec%0d", k), {va[k], vb[k]}, lfsr_vec[k]);
        check("lfsr_pass", ps[1], 1'b1);
        check("lfsr_err", e1, 8'h00);

        fy[2] = 2'd2;
        run(2, 1'b0, 0, 24);
        check("sat_done_at", first_done, 19);
        check("sat_err", e2, 2'd3);
        check("sat_first", f2, 2'd0);
        check("sat_pass", ps[2], 1'b0);

        run(3, 1'b0, 0, 8);
        check("one_done_at", first_done, 4);
        check("one_vec0", {va[0], vb[0]}, 2'b00);
        check("one_pass", ps[3], 1'b1);
        fz[3] = 2'd1;
        run(3, 1'b0, 0, 8);
        check("one_fault_err", e3, 8'd1);
        check("one_fault_first", f3, 8'd0);
        check("one_fault_pass", ps[3], 1'b0);

        mode  = 1'b0;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mid_busy", bs[0], 1'b1);
        check("mid_a", da[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bs[0], 1'b0);
        check("abort_done", dn[0], 1'b0);
        check("abort_pass", ps[0], 1'b0);
        check("abort_a", da[0], 1'b0);
        check("abort_b", db[0], 1'b0);
        #20;
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dn[0]) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_stays_idle", bs[0], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
